// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin arbiter that hands one shared I2C bus engine
// to one of NUM_REQ requesters at a time, with a per-phase watchdog.
//
// Ports:
//   clk_I2C    in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_en     in   [NUM_REQ]     per-requester request, held until done/error
//   req_wr     in   [NUM_REQ]     per-requester write/read select
//   req_wdata  in   [32*NUM_REQ]  write data, slice i = [32i+31:32i]
//   req_rdata  in   [32*NUM_REQ]  read-address word, same slicing
//   req_NM     in   [5*NUM_REQ]   byte count, slice i = [5i+4:5i]
//   grant      out  [NUM_REQ]     one-hot bus owner, zero when idle
//   req_done   out  [NUM_REQ]     one-cycle completion pulse to the owner
//   req_error  out  [NUM_REQ]     one-cycle watchdog-abort pulse to the owner
//   bus_en     out  enable to the bus engine
//   bus_wr, bus_wdata, bus_rdata, bus_NM  out  captured transaction fields
//   bus_done   in   completion from the bus engine
//   bus_busy   out  high whenever the arbiter is not idle

module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter logic [15:0] WD_CYCLES = 16'd60000
) (
    input  logic                   clk_I2C,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_en,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [32*NUM_REQ-1:0]  req_rdata,
    input  logic [5*NUM_REQ-1:0]   req_NM,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_error,
    output logic                   bus_en,
    output logic                   bus_wr,
    output logic [31:0]            bus_wdata,
    output logic [31:0]            bus_rdata,
    output logic [4:0]             bus_NM,
    input  logic                   bus_done,
    output logic                   bus_busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                bus_en_q, bus_en_d;
    logic                wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [4:0]          nm_q, nm_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_q, last_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [31:0]         wdata_a [NUM_REQ];
    logic [31:0]         rdata_a [NUM_REQ];
    logic [4:0]          nm_a    [NUM_REQ];

    logic [IW-1:0]       win;
    logic [IW-1:0]       hi_idx;
    logic [IW-1:0]       lo_idx;
    logic                hi_hit;
    logic                wd_hit;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wdata_a[g] = req_wdata[32*g +: 32];
        assign rdata_a[g] = req_rdata[32*g +: 32];
        assign nm_a[g]    = req_NM[5*g +: 5];
    end

    // Round-robin: the lowest requester above last wins; if none, wrap
    // around to the lowest requester overall. The downward scan leaves
    // the lowest matching index in each candidate.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_en[i]) begin
                lo_idx = IW'(i);
                if (i > int'(last_q)) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
        win = hi_hit ? hi_idx : lo_idx;
    end

    // The counter holds the number of edges already spent in the phase,
    // so expiry fires on the edge that completes the WD_CYCLES-th cycle.
    assign wd_hit = (cnt_q == WD_CYCLES - 16'd1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        bus_en_d = bus_en_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        nm_d     = nm_q;
        owner_d  = owner_q;
        last_d   = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req_en) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    wr_d         = req_wr[win];
                    wdata_d      = wdata_a[win];
                    rdata_d      = rdata_a[win];
                    nm_d         = nm_a[win];
                    state_d      = S_GRANT;
                end
            end
            S_GRANT: begin
                bus_en_d = 1'b1;
                state_d  = S_ACTIVE;
            end
            S_ACTIVE: begin
                // Completion wins over a coincident watchdog expiry.
                if (bus_done) begin
                    bus_en_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = S_RELEASE;
                end else if (wd_hit) begin
                    bus_en_d       = 1'b0;
                    err_d[owner_q] = 1'b1;
                    last_d         = owner_q;
                    state_d        = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!req_en[owner_q] || wd_hit) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d  = '0;
                bus_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_ACTIVE || state_q == S_RELEASE) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_I2C or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            bus_en_q <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            nm_q     <= '0;
            owner_q  <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            bus_en_q <= bus_en_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            nm_q     <= nm_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign req_done  = done_q;
    assign req_error = err_q;
    assign bus_en    = bus_en_q;
    assign bus_wr    = wr_q;
    assign bus_wdata = wdata_q;
    assign bus_rdata = rdata_q;
    assign bus_NM    = nm_q;
    assign bus_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a cycle-level reference of the arbitration rules.

module tb_i2c_bus_arbiter;

    localparam int N  = 2;
    localparam int WD = 100;

    logic            clk_I2C;
    logic            reset_n;
    logic [N-1:0]    req_en;
    logic [N-1:0]    req_wr;
    logic [32*N-1:0] req_wdata;
    logic [32*N-1:0] req_rdata;
    logic [5*N-1:0]  req_NM;
    logic [N-1:0]    grant;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_error;
    logic            bus_en;
    logic            bus_wr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;
    logic [4:0]      bus_NM;
    logic            bus_done;
    logic            bus_busy;

    logic [N-1:0]    tb_wr;
    logic [31:0]     tb_wd [N];
    logic [31:0]     tb_rd [N];
    logic [4:0]      tb_nm [N];

    int checks;
    int failures;

    i2c_bus_arbiter #(
        .NUM_REQ  (N),
        .WD_CYCLES(16'(WD))
    ) dut (
        .clk_I2C  (clk_I2C),
        .reset_n  (reset_n),
        .req_en   (req_en),
        .req_wr   (req_wr),
        .req_wdata(req_wdata),
        .req_rdata(req_rdata),
        .req_NM   (req_NM),
        .grant    (grant),
        .req_done (req_done),
        .req_error(req_error),
        .bus_en   (bus_en),
        .bus_wr   (bus_wr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_NM   (bus_NM),
        .bus_done (bus_done),
        .bus_busy (bus_busy)
    );

    initial clk_I2C = 1'b0;
    always #5 clk_I2C = ~clk_I2C;

    assign req_wr = tb_wr;
    always_comb begin
        req_wdata = '0;
        req_rdata = '0;
        req_NM    = '0;
        for (int i = 0; i < N; i++) begin
            req_wdata[32*i +: 32] = tb_wd[i];
            req_rdata[32*i +: 32] = tb_rd[i];
            req_NM[5*i +: 5]      = tb_nm[i];
        end
    end

    // ---------------- reference model ----------------
    logic [N-1:0] m_grant, m_done, m_err;
    logic         m_be, m_wait, m_wr;
    logic [31:0]  m_wd, m_rd;
    logic [4:0]   m_nm;
    int           m_owner, m_last, m_on, m_off;

    function automatic int rr(input logic [N-1:0] en, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = en >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_grant = '0; m_done = '0; m_err = '0;
        m_be = 1'b0; m_wait = 1'b0;
        m_wr = 1'b0; m_wd = '0; m_rd = '0; m_nm = '0;
        m_owner = 0; m_last = N - 1; m_on = 0; m_off = 0;
    endtask

    // m_on: bus_en-high cycles so far; m_off: cycles held after the pulse.
    task automatic model_step();
        m_done = '0;
        m_err  = '0;
        if (m_grant == '0) begin
            if (req_en != '0) begin
                m_owner = rr(req_en, m_last);
                m_grant = '0;
                m_grant[m_owner] = 1'b1;
                m_wr = tb_wr[m_owner];
                m_wd = tb_wd[m_owner];
                m_rd = tb_rd[m_owner];
                m_nm = tb_nm[m_owner];
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            m_wait = 1'b0;
            m_be = 1'b1;
            m_on = 1;
        end else if (m_be) begin
            if (bus_done) begin
                m_be = 1'b0; m_done = m_grant;
                m_last = m_owner; m_off = 1;
            end else if (m_on == WD) begin
                m_be = 1'b0; m_err = m_grant;
                m_last = m_owner; m_off = 1;
            end else begin
                m_on++;
            end
        end else begin
            if (!req_en[m_owner] || m_off == WD) m_grant = '0;
            else m_off++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_I2C);
        @(negedge clk_I2C);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_en = '0;
        bus_done = 1'b0;
        tb_wr = '0;
        for (int i = 0; i < N; i++) begin
            tb_wd[i] = '0; tb_rd[i] = '0; tb_nm[i] = '0;
        end
        @(negedge clk_I2C);
        chk("reset", 128'({grant, req_done, req_error, bus_en, bus_busy,
                           bus_wr, bus_wdata, bus_rdata, bus_NM}), 128'(0));
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic set_data();
        tb_wd[0] = 32'h0000EE1E; tb_nm[0] = 5'd2; tb_rd[0] = 32'h11;
        tb_wd[1] = 32'hB0B00001; tb_nm[1] = 5'd7; tb_rd[1] = 32'h22;
    endtask

    task automatic wait_bus_en(input string nm);
        for (int t = 0; t < 8 && !bus_en; t++) step();
        chk(nm, 128'(bus_en), 128'(1'b1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        pre_rst;
        logic [1:0]  en;
        logic        bd;
        logic [1:0]  g;
        logic        be;
        logic [1:0]  dn;
        logic [1:0]  er;
        logic [31:0] wd;
        logic [4:0]  nm;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic r, input logic [1:0] en,
                                input logic bd, input logic [1:0] g,
                                input logic be, input logic [1:0] dn);
        vec_t v;
        v.pre_rst = r; v.en = en; v.bd = bd;
        v.g = g; v.be = be; v.dn = dn; v.er = 2'b00;
        v.wd = 32'h0000EE1E; v.nm = 5'd2;
        return v;
    endfunction

    logic [N-1:0] rel, stuck;
    logic         silent, prev_be;
    int           k;

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        req_en = '0;
        bus_done = 1'b0;
        tb_wr = '0;
        model_reset();

        // single transaction from requester 0
        tbl[0] = mk(1, 2'b01, 0, 2'b01, 0, 2'b00);
        tbl[1] = mk(0, 2'b01, 0, 2'b01, 1, 2'b00);
        tbl[2] = mk(0, 2'b01, 0, 2'b01, 1, 2'b00);
        tbl[3] = mk(0, 2'b01, 1, 2'b01, 0, 2'b01);
        tbl[4] = mk(0, 2'b00, 0, 2'b00, 0, 2'b00);
        tbl[5] = mk(0, 2'b00, 0, 2'b00, 0, 2'b00);
        // both requesting: owner drops for one cycle after each done
        for (int t = 0; t < 4; t++) begin
            logic [1:0] g;
            g = (t % 2 == 0) ? 2'b01 : 2'b10;
            tbl[6+4*t]   = mk(t == 0, 2'b11, 0, g, 0, 2'b00);
            tbl[7+4*t]   = mk(0, 2'b11, 0, g, 1, 2'b00);
            tbl[8+4*t]   = mk(0, 2'b11, 1, g, 0, g);
            tbl[9+4*t]   = mk(0, 2'b11 & ~g, 0, 2'b00, 0, 2'b00);
            for (int j = 0; j < 4; j++) begin
                tbl[6+4*t+j].wd = g[0] ? 32'h0000EE1E : 32'hB0B00001;
                tbl[6+4*t+j].nm = g[0] ? 5'd2 : 5'd7;
            end
        end

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].pre_rst) begin
                do_reset();
                set_data();
            end
            req_en = tbl[i].en;
            bus_done = tbl[i].bd;
            step();
            chk($sformatf("vec%0d", i),
                128'({grant, bus_en, req_done, req_error, bus_wdata, bus_NM}),
                128'({tbl[i].g, tbl[i].be, tbl[i].dn, tbl[i].er,
                      tbl[i].wd, tbl[i].nm}));
        end

        // watchdog abort in ACTIVE
        do_reset(); set_data();
        req_en = 2'b01;
        wait_bus_en("wd_start");
        k = 0;
        for (int t = 0; t < 300 && bus_en; t++) begin
            k++;
            if (req_done != '0 || req_error != '0) begin
                chk("wd_early_pulse", 128'({req_done, req_error}), 128'(0));
            end
            step();
        end
        chk("wd_len", 128'(k), 128'(WD));
        chk("wd_pulse", 128'({req_error, req_done, grant}),
            128'({2'b01, 2'b00, 2'b01}));
        req_en = 2'b00;
        step();
        chk("wd_clear", 128'({req_error, req_done, grant}), 128'(0));

        // bus_done on the expiry cycle counts as completion
        do_reset(); set_data();
        req_en = 2'b01;
        wait_bus_en("co_start");
        k = 0;
        for (int t = 0; t < 300 && bus_en; t++) begin
            k++;
            if (k == WD) bus_done = 1'b1;
            step();
            if (k == WD) break;
        end
        chk("coincide", 128'({bus_en, req_done, req_error}),
            128'({1'b0, 2'b01, 2'b00}));
        bus_done = 1'b0;
        req_en = 2'b00;
        step();

        // owner keeps req_en high: grant force-cleared, other wins next
        do_reset(); set_data();
        req_en = 2'b01;
        wait_bus_en("hold_start");
        bus_done = 1'b1;
        step();
        bus_done = 1'b0;
        chk("hold_done", 128'({req_done, grant}), 128'({2'b01, 2'b01}));
        req_en = 2'b11;
        k = 0;
        for (int t = 0; t < 300 && grant == 2'b01; t++) begin
            k++;
            step();
        end
        chk("hold_len", 128'(k), 128'(WD));
        chk("hold_clr", 128'({grant, req_done, req_error}), 128'(0));
        step();
        chk("hold_next", 128'(grant), 128'(2'b10));

        // asynchronous reset in the middle of ACTIVE
        do_reset(); set_data();
        req_en = 2'b01;
        wait_bus_en("ar_start");
        step();
        #2 reset_n = 1'b0;
        bus_done = 1'b1;
        #1 chk("async_rst", 128'({grant, bus_en, req_done, req_error,
                                   bus_busy, bus_wdata, bus_NM}), 128'(0));
        @(negedge clk_I2C);
        chk("rst_nopulse", 128'({grant, bus_en, req_done, req_error}),
            128'(0));
        reset_n = 1'b1;
        bus_done = 1'b0;
        req_en = 2'b11;
        step();
        chk("post_rst", 128'(grant), 128'(2'b01));

        // randomized traffic against the reference model
        do_reset();
        rel = '0; stuck = '0; silent = 1'b0; prev_be = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            model_step();
            chk("rand",
                128'({grant, bus_en, req_done, req_error, bus_busy,
                      bus_wr, bus_wdata, bus_rdata, bus_NM}),
                128'({m_grant, m_be, m_done, m_err, (m_grant != '0),
                      m_wr, m_wd, m_rd, m_nm}));
            for (int i = 0; i < N; i++) begin
                if (!req_en[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_en[i] = 1'b1;
                        tb_wr[i] = 1'($urandom);
                        tb_wd[i] = $urandom;
                        tb_rd[i] = $urandom;
                        tb_nm[i] = 5'($urandom);
                        rel[i] = 1'b0;
                        stuck[i] = 1'b0;
                    end
                end else begin
                    if (req_done[i] || req_error[i]) begin
                        rel[i] = 1'b1;
                        stuck[i] = ($urandom_range(0, 9) == 0);
                    end
                    if (rel[i] && !stuck[i] && $urandom_range(0, 1) == 0) begin
                        req_en[i] = 1'b0;
                        rel[i] = 1'b0;
                    end else if (rel[i] && stuck[i] && !grant[i]) begin
                        rel[i] = 1'b0;
                        stuck[i] = 1'b0;
                    end
                end
            end
            if (bus_en) begin
                if (!prev_be) silent = ($urandom_range(0, 11) == 0);
                bus_done = !silent && ($urandom_range(0, 5) == 0);
            end else begin
                bus_done = ($urandom_range(0, 3) == 0);
            end
            prev_be = bus_en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
